jk_counter_ctrl: RTL and testbench
==================================

// Module: jk_counter_ctrl
// PURPOSE
//  Command-driven sequencer for an external WIDTH-bit bank of posedge JK flip-flops sharing clk.
//  Per cycle, it drives every bit's J/K pair to clear, load, hold or count the bank.
//  Counting runs until the bank's Q reaches a target value. Q is fed back on q_in.
//  Higher-level logic issues CLEAR/LOAD/RUN/STOP over a valid/ready command port.
// PARAMETERS
//  WIDTH  3  number of counter bits / JK flip-flops controlled
// PORTS
//  clk        in   1      clock; all state updates on posedge
//  rst        in   1      reset, asynchronous, active-high
//  cmd_valid  in   1      command present
//  cmd_ready  out  1      command accepted on posedge when cmd_valid & cmd_ready
//  cmd_op     in   2      00 CLEAR, 01 LOAD, 10 RUN, 11 STOP
//  cmd_data   in   WIDTH  LOAD: value to load; RUN: target count
//  q_in       in   WIDTH  Q outputs of the JK bank
//  j          out  WIDTH  J inputs of the JK bank
//  k          out  WIDTH  K inputs of the JK bank
//  busy       out  1      high in INIT, LOAD, CLEAR, RUN
//  done       out  1      one-cycle pulse: RUN reached target
//  err        out  1      one-cycle pulse: non-STOP command dropped in RUN
// BEHAVIOUR
//  - States: INIT, IDLE, CLEAR, LOAD, RUN, DONE. State and target/load registers are registered.
//  - j/k are combinational from registered state, registered data and q_in only.
//  - No combinational path from cmd_* to j/k.
//  - J/K patterns:
//    - hold: j=0, k=0.
//    - clear: j=0, k=all ones.
//    - load: j=v, k=~v.
//    - up-count: bit i has j=k=&q_in[i-1:0]; bit 0 is always 1.
//  - Reset (async): state=INIT, cmd_ready=0, busy=1, done=0, err=0, j=0, k=all ones.
//  - Reset mid-operation aborts immediately; no done/err is emitted.
//  - INIT: drives clear for 1 cycle, then -> IDLE. The bank reads 0 the cycle after INIT.
//  - IDLE: hold; cmd_ready=1; busy=0. On an accepted command:
//    - CLEAR -> CLEAR.
//    - LOAD -> LOAD, latching cmd_data.
//    - RUN -> RUN, latching the target.
//    - STOP -> stays IDLE (no-op).
//  - CLEAR and LOAD: drive their pattern for exactly 1 cycle, then -> IDLE; cmd_ready=0.
//  - RUN: cmd_ready=1. If q_in==target: drive hold, -> DONE. Else drive up-count (bank +1 per clk).
//    - Wrap-around: counts past 2^WIDTH-1 to 0 and continues; target is always reached in <2^WIDTH steps.
//    - RUN with target == current q_in: zero counts; goes straight to DONE.
//    - STOP accepted: the counter advances on that edge, then -> IDLE; no done.
//    - Other op accepted: dropped, err=1 next cycle, RUN continues.
//    - STOP accepted while q_in==target: target wins -> DONE, done pulses, STOP is consumed.
//  - DONE: hold; done=1 for this one cycle; cmd_ready=0; busy=0; -> IDLE.
//  - done and err are registered outputs.
//  - Latency: a RUN issued from a count of c with target t produces (t-c) mod 2^WIDTH count edges.
//    - done asserts 1 cycle after q_in first equals t in RUN.
// CONFIGURATION
//  JK_CTRL_DOWN_EN defined:
//    - Adds port cmd_dir (in, 1), sampled with RUN; 1 = down-count.
//    - Down-count pattern: bit i j=k=&(~q_in[i-1:0]); bit 0 is always 1.
//    - Wrap 0 -> 2^WIDTH-1.
//  JK_CTRL_DOWN_EN undefined: no cmd_dir port; RUN is always up-count.
//  All other behaviour is identical in both configurations.
// TESTING (WIDTH=3; bench models 3 posedge JK FFs fed by j/k)
//  1. Reset release: j=000/k=111 during INIT -> q_in=0 next cycle; cmd_ready=1 in IDLE; done=err=0.
//  2. LOAD 5, then RUN target 2:
//     - q_in sequence 5,6,7,0,1,2; exactly 5 count edges.
//     - done pulses 1 cycle after q_in=2; q_in holds 2.
//  3. RUN target = current q_in (3): no count edges; done pulses within 2 cycles; q_in stays 3.
//  4. RUN from 0 to 7, STOP accepted when q_in=3 -> q_in stops at 4; no done; state IDLE.
//  5. RUN from 0, LOAD issued mid-run -> err pulses 1 cycle; count continues to target; done pulses.
//  6. rst asserted mid-RUN (q_in=2) -> j=000/k=111 immediately; q_in=0 next edge; busy=1 until INIT exits.
//  7. With JK_CTRL_DOWN_EN: LOAD 1, RUN down target 6 -> q_in 1,0,7,6; done pulses.

Source files
------------

// File: rtl/jk_counter_ctrl_if.sv
// Command port bundle for jk_counter_ctrl: valid/ready handshake with opcode and data.
// Optional JK_CTRL_DOWN_EN adds cmd_dir (1 = down-count, sampled with RUN).
interface jk_counter_ctrl_if #(
  parameter int WIDTH = 3
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
`ifdef JK_CTRL_DOWN_EN
  logic             cmd_dir;

  modport master (output cmd_valid, output cmd_op, output cmd_data, output cmd_dir, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_op, input cmd_data, input cmd_dir, output cmd_ready);
`else
  modport master (output cmd_valid, output cmd_op, output cmd_data, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_op, input cmd_data, output cmd_ready);
`endif
endinterface

// File: rtl/jk_counter_ctrl.sv
// Command-driven sequencer producing J/K drives for an external WIDTH-bit JK flip-flop counter bank.
// Optional JK_CTRL_DOWN_EN enables down-counting selected by cmd_dir on RUN.
module jk_counter_ctrl #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  jk_counter_ctrl_if.slave cmd,
  input  logic [WIDTH-1:0] q_in,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [1:0] OP_CLEAR = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_RUN   = 2'b10;
  localparam logic [1:0] OP_STOP  = 2'b11;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_CLEAR,
    S_LOAD,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q;
  logic             latch_data;
  logic             done_d, err_d;
  logic             ready;
  logic             accept;
  logic             at_target;
  logic [WIDTH-1:0] carry_src;
  logic [WIDTH-1:0] toggle;

  assign cmd.cmd_ready = ready;
  assign accept        = cmd.cmd_valid & ready;
  assign at_target     = (q_in == data_q);

`ifdef JK_CTRL_DOWN_EN
  logic dir_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dir_q <= 1'b0;
    end else if (latch_data && cmd.cmd_op == OP_RUN) begin
      dir_q <= cmd.cmd_dir;
    end
  end

  // Down-count toggles bit i when all lower bits are zero.
  assign carry_src = dir_q ? ~q_in : q_in;
`else
  assign carry_src = q_in;
`endif

  always_comb begin
    toggle    = '0;
    toggle[0] = 1'b1;
    for (int unsigned i = 1; i < WIDTH; i++) begin
      toggle[i] = toggle[i-1] & carry_src[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_INIT;
      data_q  <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= done_d;
      err     <= err_d;
      if (latch_data) begin
        data_q <= cmd.cmd_data;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ready      = 1'b0;
    busy       = 1'b1;
    latch_data = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    j          = '0;
    k          = '0;
    case (state_q)
      S_INIT: begin
        k       = '1;
        state_d = S_IDLE;
      end
      S_IDLE: begin
        ready = 1'b1;
        busy  = 1'b0;
        if (accept) begin
          case (cmd.cmd_op)
            OP_CLEAR: state_d = S_CLEAR;
            OP_LOAD: begin
              state_d    = S_LOAD;
              latch_data = 1'b1;
            end
            OP_RUN: begin
              state_d    = S_RUN;
              latch_data = 1'b1;
            end
            default: state_d = S_IDLE;
          endcase
        end
      end
      S_CLEAR: begin
        k       = '1;
        state_d = S_IDLE;
      end
      S_LOAD: begin
        j       = data_q;
        k       = ~data_q;
        state_d = S_IDLE;
      end
      S_RUN: begin
        ready = 1'b1;
        err_d = accept && (cmd.cmd_op != OP_STOP);
        // Reaching the target takes priority over a simultaneous STOP.
        if (at_target) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          j = toggle;
          k = toggle;
          if (accept && cmd.cmd_op == OP_STOP) begin
            state_d = S_IDLE;
          end
        end
      end
      S_DONE: begin
        busy    = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_INIT;
    endcase
  end

endmodule

// File: tb/tb_jk_counter_ctrl.sv
// Scoreboard bench for jk_counter_ctrl: models a 3-bit JK bank and predicts done/err pulses
// from modular count arithmetic.
module tb_jk_counter_ctrl;
  localparam int W = 3;
  localparam int M = 1 << W;
  localparam logic [1:0] OP_CLEAR = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_RUN   = 2'b10;
  localparam logic [1:0] OP_STOP  = 2'b11;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] q;
  logic [W-1:0] j, k;
  logic         busy, done, err;

  jk_counter_ctrl_if #(.WIDTH(W)) bus ();

  jk_counter_ctrl #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .cmd  (bus),
    .q_in (q),
    .j    (j),
    .k    (k),
    .busy (busy),
    .done (done),
    .err  (err)
  );

  always #5 clk = ~clk;

  // External JK flip-flop bank
  always @(posedge clk) begin
    for (int i = 0; i < W; i++) begin
      case ({j[i], k[i]})
        2'b01:   q[i] <= 1'b0;
        2'b10:   q[i] <= 1'b1;
        2'b11:   q[i] <= ~q[i];
        default: q[i] <= q[i];
      endcase
    end
  end

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int unsigned cyc;
    int          q;
  } done_exp_t;

  done_exp_t   done_exp[$];
  int unsigned err_exp[$];
  done_exp_t   de;
  int unsigned ee;
  int          model_q;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expectations whenever the DUT pulses done or err
  always @(negedge clk) begin
    if (!rst) begin
      if (done) begin
        if (done_exp.size() == 0) check("unexpected_done", 32'd1, 32'd0);
        else begin
          de = done_exp.pop_front();
          check("done_cycle", cyc, de.cyc);
          check("done_q", 32'(q), 32'(de.q));
          check("done_busy", 32'(busy), 32'd0);
        end
      end
      if (err) begin
        if (err_exp.size() == 0) check("unexpected_err", 32'd1, 32'd0);
        else begin
          ee = err_exp.pop_front();
          check("err_cycle", cyc, ee);
        end
      end
    end
  end

  task automatic issue(input logic [1:0] op, input int data, input logic dir, input bit now,
                       output int unsigned acc);
    int b;
    if (!now) @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_data  = W'(data);
`ifdef JK_CTRL_DOWN_EN
    bus.cmd_dir   = dir;
`endif
    b = 0;
    while (!bus.cmd_ready && b < 20) begin
      @(negedge clk);
      b++;
    end
    if (!bus.cmd_ready) check("ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    acc = cyc;
    bus.cmd_valid = 1'b0;
    if (dir && op == OP_STOP) acc = cyc;
  endtask

  function automatic int steps(input int from, input int to, input logic dir);
    return dir ? (((from - to) % M) + M) % M : (((to - from) % M) + M) % M;
  endfunction

  task automatic do_load(input int v);
    int unsigned acc;
    issue(OP_LOAD, v, 1'b0, 1'b0, acc);
    model_q = v;
    repeat (2) @(negedge clk);
    check("load_q", 32'(q), 32'(v));
  endtask

  task automatic do_clear();
    int unsigned acc;
    issue(OP_CLEAR, $urandom_range(M - 1), 1'b0, 1'b0, acc);
    model_q = 0;
    repeat (2) @(negedge clk);
    check("clear_q", 32'(q), 32'd0);
  endtask

  // inject: 0 none, 1 non-STOP op mid-run (err), 2 STOP mid-run
  task automatic do_run(input int t, input logic dir, input int inject);
    int unsigned acc, acc2;
    int          n;
    done_exp_t   e;
    n = steps(model_q, t, dir);
    issue(OP_RUN, t, dir, 1'b0, acc);
    if (inject == 2) begin
      issue(OP_STOP, $urandom_range(M - 1), 1'b0, 1'b0, acc2);
      model_q = dir ? (model_q + M - 1) % M : (model_q + 1) % M;
      @(negedge clk);
      check("stop_q", 32'(q), 32'(model_q));
      check("stop_ready", 32'(bus.cmd_ready), 32'd1);
      return;
    end
    e.cyc = acc + n + 1;
    e.q   = t;
    done_exp.push_back(e);
    if (inject == 1) begin
      issue(2'($urandom_range(2)), $urandom_range(M - 1), 1'b0, 1'b0, acc2);
      err_exp.push_back(acc2);
    end
    model_q = t;
  endtask

  task automatic drain();
    int b = 0;
    while ((done_exp.size() != 0 || err_exp.size() != 0) && b < 40) begin
      @(negedge clk);
      b++;
    end
    if (done_exp.size() != 0 || err_exp.size() != 0) begin
      check("response_timeout", 32'(done_exp.size() + err_exp.size()), 32'd0);
      done_exp.delete();
      err_exp.delete();
    end
    repeat (2) @(negedge clk);
    check("hold_q", 32'(q), 32'(model_q));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int unsigned acc;
    int b, t, n, kind, inj;
    logic dir;
    q             = W'($urandom);
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = OP_STOP;
    bus.cmd_data  = '0;
`ifdef JK_CTRL_DOWN_EN
    bus.cmd_dir   = 1'b0;
`endif
    // Reset state and INIT exit
    @(negedge clk);
    check("rst_j", 32'(j), 32'd0);
    check("rst_k", 32'(k), 32'(M - 1));
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_ready", 32'(bus.cmd_ready), 32'd0);
    check("rst_done_err", 32'({done, err}), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_q", 32'(q), 32'd0);
    check("idle_ready", 32'(bus.cmd_ready), 32'd1);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_done_err", 32'({done, err}), 32'd0);
    model_q = 0;

    // LOAD 5 then RUN to 2 with wrap
    do_load(5);
    do_run(2, 1'b0, 0);
    drain();

    // RUN to the current value
    do_load(3);
    do_run(3, 1'b0, 0);
    drain();

    // STOP accepted at q=3 while running 0 -> 7
    do_load(0);
    issue(OP_RUN, 7, 1'b0, 1'b0, acc);
    b = 0;
    while (q != 3 && b < 20) begin
      @(negedge clk);
      b++;
    end
    check("stop_reach3", 32'(q), 32'd3);
    issue(OP_STOP, 0, 1'b0, 1'b1, acc);
    @(negedge clk);
    check("stop_at4", 32'(q), 32'd4);
    check("stop_idle_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    check("stop_hold4", 32'(q), 32'd4);
    model_q = 4;

    // LOAD mid-run is dropped with err
    do_load(0);
    do_run(6, 1'b0, 1);
    drain();

    // Reset mid-run
    do_load(0);
    issue(OP_RUN, 7, 1'b0, 1'b0, acc);
    b = 0;
    while (q != 2 && b < 20) begin
      @(negedge clk);
      b++;
    end
    rst = 1'b1;
    #1;
    check("midrst_j", 32'(j), 32'd0);
    check("midrst_k", 32'(k), 32'(M - 1));
    check("midrst_busy", 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    check("midrst_q", 32'(q), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy_init", 32'(busy), 32'd1);
    @(negedge clk);
    check("midrst_busy_idle", 32'(busy), 32'd0);
    check("midrst_q_idle", 32'(q), 32'd0);
    model_q = 0;

`ifdef JK_CTRL_DOWN_EN
    do_load(1);
    do_run(6, 1'b1, 0);
    drain();
`endif

    // Randomized command mix
    for (int it = 0; it < 40; it++) begin
      kind = $urandom_range(4);
      case (kind)
        0: do_load($urandom_range(M - 1));
        1: do_clear();
        2: begin
          issue(OP_STOP, $urandom_range(M - 1), 1'b0, 1'b0, acc);
          repeat (2) @(negedge clk);
          check("idle_stop_q", 32'(q), 32'(model_q));
        end
        default: begin
          t = $urandom_range(M - 1);
`ifdef JK_CTRL_DOWN_EN
          dir = 1'($urandom_range(1));
`else
          dir = 1'b0;
`endif
          n   = steps(model_q, t, dir);
          inj = (n >= 2) ? $urandom_range(2) : 0;
          do_run(t, dir, inj);
          drain();
        end
      endcase
    end

    drain();
    check("final_queues", 32'(done_exp.size() + err_exp.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
